// File: rtl/posit_pkg.sv
// Purpose: shared widths, decoded-posit record and NaR pattern for the posit datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package posit_pkg;

  localparam int N  = 32;                   // posit width
  localparam int ES = 2;                    // exponent field width
  localparam int SW = $clog2(N) + ES + 1;   // signed scale width
  localparam int FW = N - ES - 2;           // fraction width incl. hidden bit
  localparam int MW = $clog2(N);            // regime run-length width

  typedef struct packed {
    logic          sign;
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
    logic          zero;
    logic          nar;
  } posit_dec_t;

  // NaR is a lone 1 in the sign position followed by zeros.
  function automatic logic [N-1:0] nar_pattern(input int width);
    logic [N-1:0] p;
    p = '0;
    p[width-1] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/posit_run_cnt.sv
// Purpose: leading-run counter over the posit body (regime length).
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   body  N-1 bit posit body (sign stripped, magnitude form)
//   r     polarity of the run (body MSB)
//   m     length of the leading run of bits equal to r, 1..N-1
module posit_run_cnt
  import posit_pkg::*;
(
  input  logic [N-2:0]  body,
  input  logic          r,
  output logic [MW-1:0] m
);

  always_comb begin
    logic run;
    m   = '0;
    run = 1'b1;
    // Count from the MSB until the first bit that breaks the run.
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (body[i] == r)) begin
        m = m + MW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// Purpose: two-stage posit decoder -> sign, scale (k*2^ES+e), hidden-bit fraction, zero/NaR flags.
// Latency: 2 cycles accept->out_valid, 1 item/cycle.
// Backpressure: S2 holds while out_valid&!out_ready; S1 fills behind it, then in_ready drops.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake, in_posit is the raw N-bit posit
//   out_valid/out_ready   output handshake
//   out_sign/out_scale/out_frac/out_zero/out_nar  decoded fields (held while stalled)
module posit_decode_pipe
  import posit_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_posit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [SW-1:0] out_scale,
  output logic [FW-1:0] out_frac,
  output logic          out_zero,
  output logic          out_nar
);

  logic          s1_vld;
  logic          s2_vld;
  logic          s1_adv;
  logic          s1_sign;
  logic          s1_zero;
  logic          s1_nar;
  logic [N-2:0]  s1_body;
  logic [N-2:0]  in_body;
  posit_dec_t    s2_dat;
  posit_dec_t    s2_nxt;
  logic [MW-1:0] run_m;
  logic [MW:0]   drop;
  logic [N-2:0]  rest;
  logic [SW-1:0] k_val;
  logic [SW-1:0] e_val;

  // S2 can take a new item when empty or when its current item leaves now.
  assign s1_adv   = !s2_vld || out_ready;
  assign in_ready = !s1_vld || s1_adv;

  // Low N-1 bits of the two's complement only depend on the low N-1 input bits.
  assign in_body = in_posit[N-1] ? -in_posit[N-2:0] : in_posit[N-2:0];

  posit_run_cnt u_run_cnt (
    .body (s1_body),
    .r    (s1_body[N-2]),
    .m    (run_m)
  );

  always_comb begin
    // Shift out run + terminator; a run that fills the body shifts everything out,
    // which leaves e=0 and a bare hidden bit.
    drop  = {1'b0, run_m} + (MW + 1)'(1);
    rest  = s1_body << drop;
    k_val = s1_body[N-2] ? (SW'(run_m) - SW'(1)) : -SW'(run_m);
    e_val = SW'(rest >> (N - 1 - ES));

    s2_nxt      = '0;
    s2_nxt.sign = s1_sign;
    s2_nxt.zero = s1_zero;
    s2_nxt.nar  = s1_nar;
    if (!(s1_zero || s1_nar)) begin
      s2_nxt.scale = (k_val << ES) + e_val;
      s2_nxt.frac  = {1'b1, rest[N-2-ES -: FW-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_nar  <= 1'b0;
      s1_body <= '0;
      s2_dat  <= '0;
    end else begin
      if (s1_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_dat <= s2_nxt;
        end
      end
      if (in_ready) begin
        s1_vld <= in_valid;
        if (in_valid) begin
          s1_sign <= in_posit[N-1];
          s1_zero <= (in_posit == '0);
          s1_nar  <= (in_posit == nar_pattern(N));
          s1_body <= in_body;
        end
      end
    end
  end

  assign out_valid = s2_vld;
  assign out_sign  = s2_dat.sign;
  assign out_scale = s2_dat.scale;
  assign out_frac  = s2_dat.frac;
  assign out_zero  = s2_dat.zero;
  assign out_nar   = s2_dat.nar;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Purpose: self-checking bench for posit_decode_pipe (N=32, ES=2).
// Latency: expects 2 cycles accept->out_valid.
// Backpressure: exercises stalls, back-to-back streaming and reset with a full pipe.
module tb_posit_decode_pipe;

  localparam int TFW = 28;
  localparam int TES = 2;

  typedef struct {
    logic            sign;
    int              scale;
    logic [TFW-1:0]  frac;
    logic            zero;
    logic            nar;
  } dec_t;

  typedef struct {
    logic [31:0] p;
    dec_t        d;
  } vec_t;

  typedef struct {
    dec_t d;
    int   cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_posit;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_scale;
  logic [27:0] out_frac;
  logic        out_zero;
  logic        out_nar;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_out = 0;
  exp_t exp_q[$];
  logic chk_lat = 1'b0;
  logic prev_stall = 1'b0;
  dec_t prev_out;
  dec_t got;
  logic in_fire;
  logic out_fire;
  logic s_in_ready;
  logic s_out_valid;
  vec_t tbl[11];

  posit_decode_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_scale (out_scale),
    .out_frac  (out_frac),
    .out_zero  (out_zero),
    .out_nar   (out_nar)
  );

  always #5 clk = ~clk;

  // Reference decoder: walks the body as a bit list following the posit field rules.
  function automatic dec_t ref_decode(input logic [31:0] p);
    dec_t    d;
    bit      q[$];
    bit      r;
    int      m;
    int      k;
    int      e;
    longint  mag;
    logic [TFW-1:0] f;
    d.sign  = p[31];
    d.scale = 0;
    d.frac  = '0;
    d.zero  = (p == 32'h0);
    d.nar   = (p == 32'h8000_0000);
    if (d.zero || d.nar) return d;
    mag = p[31] ? (64'h1_0000_0000 - longint'(p)) : longint'(p);
    for (int i = 30; i >= 0; i--) q.push_back(mag[i]);
    r = q[0];
    m = 0;
    while (q.size() > 0 && q[0] == r) begin
      m++;
      void'(q.pop_front());
    end
    if (q.size() > 0) void'(q.pop_front());
    k = r ? m - 1 : -m;
    e = 0;
    for (int i = 0; i < TES; i++) begin
      e = e * 2;
      if (q.size() > 0) e = e + int'(q.pop_front());
    end
    d.scale = k * (1 << TES) + e;
    f = '0;
    f[TFW-1] = 1'b1;
    for (int i = TFW - 2; i >= 0; i--) begin
      if (q.size() > 0) f[i] = q.pop_front();
    end
    d.frac = f;
    return d;
  endfunction

  function automatic logic [63:0] dec_bits(input dec_t d);
    return {1'b0, d.sign, d.scale[31:0], d.frac, d.zero, d.nar};
  endfunction

  function automatic dec_t cur_out();
    dec_t o;
    o.sign  = out_sign;
    o.scale = int'($signed(out_scale));
    o.frac  = out_frac;
    o.zero  = out_zero;
    o.nar   = out_nar;
    return o;
  endfunction

  function automatic vec_t mk(input logic [31:0] p, input logic s, input int sc,
                              input logic [27:0] fr, input logic z, input logic n);
    vec_t v;
    v.p       = p;
    v.d.sign  = s;
    v.d.scale = sc;
    v.d.frac  = fr;
    v.d.zero  = z;
    v.d.nar   = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // One cycle: inputs were set at the preceding negedge; sample mid-low-phase,
  // run the scoreboard, then wait for the next negedge.
  task automatic step();
    dec_t o;
    exp_t e;
    #2;
    o           = cur_out();
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    in_fire     = in_valid && in_ready;
    out_fire    = out_valid && out_ready;
    if (prev_stall) begin
      chk("stall_valid_held", 64'(out_valid), 64'd1);
      chk("stall_data_held", dec_bits(o), dec_bits(prev_out));
    end
    if (out_fire) begin
      got = o;
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", dec_bits(o), dec_bits(e.d));
        if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
    if (in_fire) exp_q.push_back('{d: ref_decode(in_posit), cyc: cyc});
    prev_stall = out_valid && !out_ready;
    prev_out   = o;
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] rand_posit();
    logic [31:0] r;
    int          sh;
    r  = $urandom;
    sh = $urandom_range(0, 31);
    case ($urandom_range(0, 3))
      0:       return r;
      1:       return r >> sh;
      2:       return 32'h7FFF_FFFF ^ (r >> sh);
      default: return -(r >> sh);
    endcase
  endfunction

  task automatic drain(input string name);
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      step();
      budget++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] items[3];
    int          idx;
    int          out_base;
    int          budget;

    tbl[0]  = mk(32'h4000_0000, 1'b0,    0, 28'h800_0000, 1'b0, 1'b0);
    tbl[1]  = mk(32'hC000_0000, 1'b1,    0, 28'h800_0000, 1'b0, 1'b0);
    tbl[2]  = mk(32'h4800_0000, 1'b0,    1, 28'h800_0000, 1'b0, 1'b0);
    tbl[3]  = mk(32'h7FFF_FFFF, 1'b0,  120, 28'h800_0000, 1'b0, 1'b0);
    tbl[4]  = mk(32'h0000_0001, 1'b0, -120, 28'h800_0000, 1'b0, 1'b0);
    tbl[5]  = mk(32'h0000_0000, 1'b0,    0, 28'h000_0000, 1'b1, 1'b0);
    tbl[6]  = mk(32'h8000_0000, 1'b1,    0, 28'h000_0000, 1'b0, 1'b1);
    tbl[7]  = mk(32'h3C00_0000, 1'b0,   -1, 28'hC00_0000, 1'b0, 1'b0);
    tbl[8]  = mk(32'h7FFF_FFFE, 1'b0,  116, 28'h800_0000, 1'b0, 1'b0);
    tbl[9]  = mk(32'h7FFF_FFFD, 1'b0,  114, 28'h800_0000, 1'b0, 1'b0);
    tbl[10] = mk(32'hFFFF_FFFF, 1'b1, -120, 28'h800_0000, 1'b0, 1'b0);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_posit  = '0;
    out_ready = 1'b0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_outputs", dec_bits(cur_out()), 64'd0);
    #1;

    // Table vectors, one item in flight at a time.
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      in_valid = 1'b1;
      in_posit = tbl[i].p;
      budget   = 0;
      do begin
        step();
        budget++;
      end while (!in_fire && budget < 10);
      in_valid = 1'b0;
      budget   = 0;
      do begin
        step();
        budget++;
      end while (!out_fire && budget < 10);
      if (!out_fire) begin
        chk($sformatf("tbl%0d_timeout", i), 64'd0, 64'd1);
      end else begin
        chk($sformatf("tbl%0d_sign", i),  64'(got.sign),  64'(tbl[i].d.sign));
        chk($sformatf("tbl%0d_scale", i), 64'(got.scale), 64'(tbl[i].d.scale));
        chk($sformatf("tbl%0d_frac", i),  64'(got.frac),  64'(tbl[i].d.frac));
        chk($sformatf("tbl%0d_zero", i),  64'(got.zero),  64'(tbl[i].d.zero));
        chk($sformatf("tbl%0d_nar", i),   64'(got.nar),   64'(tbl[i].d.nar));
      end
    end

    // Back-to-back random stream: every cycle accepted, fixed 2-cycle latency.
    chk_lat = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_posit = rand_posit();
      step();
      chk("b2b_in_ready", 64'(s_in_ready), 64'd1);
    end
    drain("b2b_drain");
    chk_lat = 1'b0;

    // Stall: consumer blocked for 5 cycles while 3 items are offered.
    foreach (items[i]) items[i] = rand_posit();
    out_ready = 1'b0;
    idx       = 0;
    out_base  = n_out;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_posit = items[idx];
      step();
      if (in_fire) idx++;
      if (c >= 2) begin
        chk("stall_in_ready_low", 64'(s_in_ready), 64'd0);
        chk("stall_out_valid", 64'(s_out_valid), 64'd1);
      end
    end
    chk("stall_items_held", 64'(idx), 64'd2);
    out_ready = 1'b1;
    budget    = 0;
    while (idx < 3 && budget < 20) begin
      in_valid = 1'b1;
      in_posit = items[idx];
      step();
      if (in_fire) idx++;
      budget++;
    end
    drain("stall_drain");
    chk("stall_out_count", 64'(n_out - out_base), 64'd3);

    // Reset with a full pipe: nothing in flight may reappear.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_posit = rand_posit();
      step();
    end
    in_valid = 1'b0;
    step();
    chk("full_before_reset", 64'(s_out_valid), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n      = 1'b1;
    prev_stall = 1'b0;
    exp_q.delete();
    out_ready  = 1'b1;
    #1;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_outputs", dec_bits(cur_out()), 64'd0);
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    cyc++;
    out_base = n_out;
    for (int i = 0; i < 6; i++) step();
    chk("rst2_no_stale", 64'(n_out - out_base), 64'd0);

    // One more item after reset to confirm the pipe still works.
    in_valid = 1'b1;
    in_posit = 32'h4800_0000;
    step();
    drain("post_reset_drain");
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
